// File: rtl/ex3_arbiter_if.sv
// Requester, datapath and response signal bundle for ex3_arbiter.
// slave is the arbiter's view; master is the surrounding client/datapath view.
interface ex3_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [4*NUM_REQ-1:0]  req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [16*NUM_REQ-1:0] req_c;
   logic                  dp_reset;
   logic [3:0]            dp_a;
   logic [15:0]           dp_b;
   logic [15:0]           dp_c;
   logic [15:0]           dp_out;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [15:0]           rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  busy;
   logic                  rsp_drop;

   modport slave (
      input  req_valid, req_a, req_b, req_c, dp_out, rsp_ready,
      output req_ready, dp_reset, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, busy, rsp_drop
   );

   modport master (
      output req_valid, req_a, req_b, req_c, dp_out, rsp_ready,
      input  req_ready, dp_reset, dp_a, dp_b, dp_c, rsp_valid, rsp_data, rsp_id, busy, rsp_drop
   );
endinterface

// File: rtl/ex3_arbiter.sv
// Round-robin arbiter/sequencer sharing one Exercise3 datapath among NUM_REQ requesters.
// Define EX3_ARB_TIMEOUT_EN to drop responses that wait TIMEOUT cycles without a handshake.
module ex3_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned RUN_CYCLES = 5,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic          clk,
   input logic          reset,
   ex3_arbiter_if.slave bus
);
   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned RCW = $clog2(RUN_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   if (NUM_REQ < 2 || NUM_REQ > 8 || RUN_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
      $error("ex3_arbiter: parameter out of range");
   end

   logic [1:0]         state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [3:0]         a_q, a_d;
   logic [15:0]        b_q, b_d;
   logic [15:0]        c_q, c_d;
   logic [15:0]        data_q, data_d;
   logic [RCW-1:0]     rcnt_q, rcnt_d;

   logic               hit;
   logic [IDW-1:0]     gidx;
   logic [IDW-1:0]     idx;
   logic [NUM_REQ-1:0] grant;
   logic               drop;
   logic [3:0]         a_sel;
   logic [15:0]        b_sel;
   logic [15:0]        c_sel;

`ifdef EX3_ARB_TIMEOUT_EN
   localparam int unsigned WCW = $clog2(TIMEOUT + 1);
   logic [WCW-1:0]     wcnt_q, wcnt_d;
`endif

   // First valid requester after the round-robin pointer, with wrap.
   always_comb begin
      hit  = 1'b0;
      gidx = '0;
      idx  = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         idx = IDW'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (!hit && bus.req_valid[idx]) begin
            hit  = 1'b1;
            gidx = idx;
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      c_sel = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gidx == IDW'(i)) begin
            a_sel = bus.req_a[4*i +: 4];
            b_sel = bus.req_b[16*i +: 16];
            c_sel = bus.req_c[16*i +: 16];
         end
      end
   end

   // Next-state and datapath sequencing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      data_d  = data_q;
      rcnt_d  = rcnt_q;
      grant   = '0;
      drop    = 1'b0;
`ifdef EX3_ARB_TIMEOUT_EN
      wcnt_d  = wcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               grant[gidx] = 1'b1;
               a_d         = a_sel;
               b_d         = b_sel;
               c_d         = c_sel;
               id_d        = gidx;
               ptr_d       = gidx;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            rcnt_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            rcnt_d = rcnt_q + RCW'(1);
            if (rcnt_q == RCW'(RUN_CYCLES - 1)) begin
               data_d  = bus.dp_out;
               state_d = S_RESP;
`ifdef EX3_ARB_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
`ifdef EX3_ARB_TIMEOUT_EN
            else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
               drop    = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= IDW'(NUM_REQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         data_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         data_q  <= data_d;
         rcnt_q  <= rcnt_d;
      end
   end

`ifdef EX3_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wcnt_q <= '0;
      else        wcnt_q <= wcnt_d;
   end
`endif

   // Grant is only meaningful out of reset; datapath is held in reset while we are.
   assign bus.req_ready = reset ? grant : '0;
   assign bus.dp_reset  = !reset || (state_q == S_LOAD);
   assign bus.dp_a      = a_q;
   assign bus.dp_b      = b_q;
   assign bus.dp_c      = c_q;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_id    = id_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rsp_drop  = drop;
endmodule

// File: tb/tb_ex3_arbiter.sv
// Scoreboard bench for ex3_arbiter with a counting stub in place of the Exercise3 datapath.
module tb_ex3_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int RUN_CYCLES = 5;
   localparam int TIMEOUT    = 3;
   localparam int IDW        = $clog2(NUM_REQ);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex3_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   ex3_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .RUN_CYCLES(RUN_CYCLES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   // Stub datapath: result depends on operands and on clocks since its reset.
   logic [15:0] stub_cnt;
   always_ff @(posedge clk) stub_cnt <= bus.dp_reset ? 16'd0 : stub_cnt + 16'd1;
   assign bus.dp_out = (bus.dp_b ^ bus.dp_c) + {bus.dp_a, 12'h000} + 16'(stub_cnt * 16'h0111);

   function automatic logic [15:0] exp_data(input logic [3:0] a, input logic [15:0] b, input logic [15:0] c);
      return 16'((b ^ c) + {a, 12'h000} + 16'((RUN_CYCLES - 1) * 16'h0111));
   endfunction

   typedef struct {
      int          id;
      logic [15:0] data;
   } exp_t;

   exp_t               exp_q[$];
   int                 glog[$];
   int                 gcyc[$];
   logic [NUM_REQ-1:0] v;
   logic [3:0]         oa[NUM_REQ];
   logic [15:0]        ob[NUM_REQ];
   logic [15:0]        oc[NUM_REQ];
   int                 g_seen = -1;
   int                 cyc = 0;
   int                 n_vec = 0;
   int                 n_err = 0;
   int                 n_rsp = 0;
   int                 n_drop = 0;
   int                 refill_pct = 0;
   int                 wd_pct = 0;
   int                 rdy_pct = 100;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   task automatic drive();
      bus.req_valid = v;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_a[4*i +: 4]   = oa[i];
         bus.req_b[16*i +: 16] = ob[i];
         bus.req_c[16*i +: 16] = oc[i];
      end
   endtask

   // One clock of stimulus: retire the granted request, then randomise the rest.
   task automatic step();
      @(posedge clk);
      #1;
      if (g_seen >= 0) v[g_seen] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[i] && int'($urandom_range(99)) < wd_pct) begin
            v[i] = 1'b0;
         end else if (!v[i] && int'($urandom_range(99)) < refill_pct) begin
            oa[i] = 4'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 16'($urandom);
            v[i]  = 1'b1;
         end
      end
      bus.rsp_ready = (int'($urandom_range(99)) < rdy_pct);
      drive();
   endtask

   // Reference model and monitor, sampled on the falling edge.
   bit          act = 1'b0;
   int          t_g = 0;
   int          m_ptr = NUM_REQ - 1;
   logic [35:0] cur_ops = '0;

   always @(negedge clk) begin
      logic [NUM_REQ-1:0] exp_rdy;
      int                 gi;
      int                 ph;
      int                 idx;
      bit                 exp_rv;
      bit                 exp_drop;
      cyc++;
      g_seen = -1;
      if (!rst_n) begin
         chk("rst_busy",      64'(bus.busy),      64'(0));
         chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
         chk("rst_dp_reset",  64'(bus.dp_reset),  64'(1));
         chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
         chk("rst_rsp_drop",  64'(bus.rsp_drop),  64'(0));
         act     = 1'b0;
         m_ptr   = NUM_REQ - 1;
         cur_ops = '0;
         exp_q.delete();
      end else begin
         exp_rdy = '0;
         gi      = -1;
         if (!act) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (m_ptr + k) % NUM_REQ;
               if (gi < 0 && v[idx]) gi = idx;
            end
         end
         if (gi >= 0) exp_rdy[gi] = 1'b1;
         chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
         chk("busy", 64'(bus.busy), 64'(act));
         ph = cyc - t_g;
         chk("dp_reset", 64'(bus.dp_reset), 64'(act && ph == 1));
         exp_rv = act && ph >= RUN_CYCLES + 2;
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
         chk("dp_ops", 64'({bus.dp_a, bus.dp_b, bus.dp_c}), 64'(cur_ops));
         exp_drop = 1'b0;
         if (exp_rv) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 64'(1), 64'(0));
            end else begin
               chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
               chk("rsp_id",   64'(bus.rsp_id),   64'(exp_q[0].id));
            end
            if (bus.rsp_ready) begin
               void'(exp_q.pop_front());
               act = 1'b0;
               n_rsp++;
            end
`ifdef EX3_ARB_TIMEOUT_EN
            else if (ph == RUN_CYCLES + 1 + TIMEOUT) begin
               exp_drop = 1'b1;
               void'(exp_q.pop_front());
               act = 1'b0;
               n_drop++;
            end
`endif
         end
         chk("rsp_drop", 64'(bus.rsp_drop), 64'(exp_drop));
         if (gi >= 0) begin
            act     = 1'b1;
            t_g     = cyc;
            m_ptr   = gi;
            cur_ops = {oa[gi], ob[gi], oc[gi]};
            exp_q.push_back('{gi, exp_data(oa[gi], ob[gi], oc[gi])});
            g_seen  = gi;
            glog.push_back(gi);
            gcyc.push_back(cyc);
         end
      end
   end

   initial begin
      int fs;
      rst_n         = 1'b0;
      v             = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         oa[i] = '0;
         ob[i] = '0;
         oc[i] = '0;
      end
      drive();
      repeat (3) step();
      rst_n = 1'b1;

      // Single request from requester 2.
      oa[2] = 4'h5;
      ob[2] = 16'h1234;
      oc[2] = 16'hABCD;
      v[2]  = 1'b1;
      drive();
      repeat (12) step();

      // Fairness from a fresh reset with everyone requesting.
      rst_n = 1'b0;
      repeat (2) step();
      rst_n      = 1'b1;
      fs         = glog.size();
      v          = '1;
      refill_pct = 100;
      drive();
      repeat (42) step();
      refill_pct = 0;
      if (glog.size() < fs + 5) begin
         chk("fair_grant_count", 64'(glog.size() - fs), 64'(5));
      end else begin
         for (int k = 0; k < 5; k++) chk("fair_order", 64'(glog[fs+k]), 64'(k % NUM_REQ));
         for (int k = 1; k < 5; k++) chk("fair_period", 64'(gcyc[fs+k] - gcyc[fs+k-1]), 64'(RUN_CYCLES + 3));
      end
      v = '0;
      drive();
      repeat (12) step();

      // Backpressure, then late arrival while busy.
      oa[1]   = 4'hA;
      ob[1]   = 16'h0F0F;
      oc[1]   = 16'h3C3C;
      v[1]    = 1'b1;
      rdy_pct = 0;
      drive();
      repeat (3) step();
      oa[3] = 4'h7;
      ob[3] = 16'h5555;
      oc[3] = 16'h00FF;
      v[3]  = 1'b1;
      drive();
      repeat (14) step();
      rdy_pct = 100;
      repeat (20) step();

      // Reset in the middle of a run, then everybody requests.
      oa[3] = 4'h2;
      v[3]  = 1'b1;
      drive();
      repeat (4) step();
      rst_n = 1'b0;
      repeat (2) step();
      fs    = glog.size();
      v     = '1;
      drive();
      rst_n = 1'b1;
      repeat (3) step();
      if (glog.size() <= fs) chk("post_reset_grant_count", 64'(glog.size() - fs), 64'(1));
      else                   chk("post_reset_first_grant", 64'(glog[fs]), 64'(0));
      v = '0;
      drive();
      repeat (12) step();

      // Random traffic.
      refill_pct = 30;
      wd_pct     = 5;
      rdy_pct    = 60;
      repeat (3000) step();
      refill_pct = 0;
      wd_pct     = 0;
      rdy_pct    = 100;
      v          = '0;
      drive();
      repeat (20) step();

      chk("responses_seen", 64'(n_rsp > 50), 64'(1));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ex3_arbiter.md
Name: ex3_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Exercise3 datapath instance among NUM_REQ requesters.
- Accepts one operand set (a, b, c) per transaction.
- Pulses the datapath reset to load the operands, then lets the datapath run for RUN_CYCLES clocks.
- Captures the datapath output and returns it, tagged with the requester id, over a valid/ready response channel.
- Sits between client logic and the Exercise3 instance; Exercise3 itself is unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RUN_CYCLES, 5, datapath run cycles after load (>=1); 5 covers one full count sequence
TIMEOUT, 16, response wait limit in cycles; used only with EX3_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high, only in IDLE
req_a  in  4*NUM_REQ  packed a operands; requester i uses [4i+3:4i]
req_b  in  16*NUM_REQ  packed b operands
req_c  in  16*NUM_REQ  packed c operands
dp_reset  out  1  active-high reset to the datapath
dp_a  out  4  datapath a
dp_b  out  16  datapath b
dp_c  out  16  datapath c
dp_out  in  16  datapath result
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  16  captured dp_out
rsp_id  out  $clog2(NUM_REQ)  id of the served requester
busy  out  1  state != IDLE
rsp_drop  out  1  timeout drop pulse (tied 0 without the macro)

Behaviour:
- Reset (reset low, immediate): state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - Operand registers, rsp_data and rsp_id = 0.
  - rsp_valid, req_ready, busy, rsp_drop = 0.
  - dp_reset = 1 (combinationally forced high while reset is low).
- FSM states: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, pick the first valid requester, searching from pointer+1 with wrap.
  - Drive req_ready[g] = 1 in that same cycle; this is the acceptance.
  - At the clock edge: capture req_a/b/c[g] and id g, set pointer = g, go to LOAD.
  - No valid requester: stay in IDLE with req_ready = 0.
- LOAD (1 cycle): dp_reset = 1; dp_a/b/c driven from the operand registers. Next state RUN, run counter = 0.
- RUN:
  - dp_reset = 0; counter increments every cycle.
  - When counter == RUN_CYCLES-1, capture dp_out into rsp_data at that edge, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable.
  - On rsp_valid & rsp_ready, go to IDLE at the edge.
  - dp_out changes are ignored in this state.
- Outputs outside LOAD/RUN/RESP:
  - dp_a/b/c hold their last operands in every state.
  - dp_reset = 0 outside LOAD and reset.
- Timing, with acceptance cycle = 0:
  - dp_reset high in cycle 1.
  - RUN in cycles 2..RUN_CYCLES+1.
  - rsp_valid from cycle RUN_CYCLES+2.
  - Minimum transaction period = RUN_CYCLES+3 cycles.
- Requests arriving outside IDLE wait; a requester may deassert req_valid before it is granted with no side effects.
- Reset asserted mid-transaction: the transaction is abandoned and no response is issued.

Optional Feature:
EX3_ARB_TIMEOUT_EN
- Defined: RESP counts waiting cycles. If no handshake has occurred by the TIMEOUT-th RESP cycle:
  - rsp_drop = 1 for that one cycle;
  - the response is discarded;
  - the next state is IDLE.
  A handshake in that same cycle takes precedence (no drop).
- Undefined: RESP waits indefinitely; rsp_drop is tied to 0; TIMEOUT is ignored.

Test Plan:
All scenarios use NUM_REQ=4, RUN_CYCLES=5.
- Single request: requester 2 with a=0x5, b=0x1234, c=0xABCD; stub dp_out=0xBEEF in the last RUN cycle; rsp_ready=1 -> req_ready=4'b0100 in cycle 0; dp_reset high in cycle 1 only; dp_a/b/c=0x5/0x1234/0xABCD from cycle 1; rsp_valid in cycle 7 with rsp_data=0xBEEF, rsp_id=2; busy=0 in cycle 8.
- Fairness: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 8 cycles.
- Backpressure: rsp_ready low for 10 cycles while dp_out toggles -> rsp_valid, rsp_data and rsp_id stay stable; req_ready stays 0; handshake in cycle 17 -> IDLE in cycle 18.
- Reset mid-RUN: reset low in cycle 4 -> immediately busy=0, rsp_valid=0, dp_reset=1; after release with all requesters valid, requester 0 is granted first.
- Late arrival: requester 1 raises req_valid in cycle 3 while requester 0 is served -> requester 1 is not granted until the IDLE cycle 8.
- With EX3_ARB_TIMEOUT_EN and TIMEOUT=3, rsp_ready=0 -> rsp_valid in cycles 7-9; rsp_drop=1 in cycle 9 only; IDLE in cycle 10. Repeating with rsp_ready=1 in cycle 9 gives a handshake and rsp_drop=0.
